// File: rtl/color_band_gen_if.sv
// -----------------------------------------------------------------------------
// color_band_gen_if
// Bundles the pixel-stream, control, palette-write and colour-output signals
// of color_band_gen. clk and reset stay as plain ports on the module.
//
//   master : pattern source / testbench side (drives pixel, control, palette)
//   slave  : color_band_gen side (drives colour outputs and pixel_valid)
//
// Signals
//   pixel_on     active-video qualifier
//   x, y         current pixel coordinates (COORD_W each)
//   frame_start  one-cycle pulse per frame
//   mode         0 = bands stacked along y, 1 = bands stacked along x
//   scroll_en    enables band scrolling
//   pal_wr       palette write strobe
//   pal_idx      palette entry to write
//   pal_data     palette data {R,G,B}
//   red_out, green_out, blue_out  registered colour
//   pixel_valid  pixel_on aligned with the colour outputs
// -----------------------------------------------------------------------------
interface color_band_gen_if #(
  parameter int COLOR_W = 4,
  parameter int COORD_W = 10
);
  logic                   pixel_on;
  logic [COORD_W-1:0]     x;
  logic [COORD_W-1:0]     y;
  logic                   frame_start;
  logic                   mode;
  logic                   scroll_en;
  logic                   pal_wr;
  logic [2:0]             pal_idx;
  logic [3*COLOR_W-1:0]   pal_data;
  logic [COLOR_W-1:0]     red_out;
  logic [COLOR_W-1:0]     green_out;
  logic [COLOR_W-1:0]     blue_out;
  logic                   pixel_valid;

  modport master (
    output pixel_on, x, y, frame_start, mode, scroll_en, pal_wr, pal_idx, pal_data,
    input  red_out, green_out, blue_out, pixel_valid
  );

  modport slave (
    input  pixel_on, x, y, frame_start, mode, scroll_en, pal_wr, pal_idx, pal_data,
    output red_out, green_out, blue_out, pixel_valid
  );
endinterface

// File: rtl/color_band_gen.sv
// -----------------------------------------------------------------------------
// color_band_gen
// Generates horizontal or vertical colour bands from a writable palette, with
// optional slow scrolling driven by frame_start pulses.
//
// Ports
//   clk    single clock, all logic on its rising edge
//   reset  synchronous, active-high
//   bus    color_band_gen_if.slave (pixel stream, control, palette write,
//          registered colour outputs and pixel_valid)
//
// Optional feature
//   COLOR_BAND_GEN_BORDER_EN : when defined, the first pixel of every band
//   (coord + offset a multiple of BAND_SIZE) is drawn white while pixel_on=1.
// -----------------------------------------------------------------------------
module color_band_gen #(
  parameter int COLOR_W    = 4,
  parameter int COORD_W    = 10,
  parameter int NUM_BANDS  = 3,
  parameter int BAND_SIZE  = 160,
  parameter int SCROLL_DIV = 4
) (
  input logic              clk,
  input logic              reset,
  color_band_gen_if.slave  bus
);

  localparam int PERIOD = NUM_BANDS * BAND_SIZE;
  localparam int OFF_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int FC_W   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  // Wide enough that coord + offset can never wrap.
  localparam int SUM_W  = ((COORD_W > OFF_W) ? COORD_W : OFF_W) + 4;
  localparam int PIX_W  = 3 * COLOR_W;

  localparam logic [OFF_W-1:0] OFF_LAST    = OFF_W'(PERIOD - 1);
  localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(SCROLL_DIV - 1);
  localparam logic [SUM_W-1:0] BAND_SIZE_S = SUM_W'(BAND_SIZE);
  localparam logic [SUM_W-1:0] NUM_BANDS_S = SUM_W'(NUM_BANDS);

  // Reset colour of a palette entry: green, yellow, red, then black.
  function automatic logic [PIX_W-1:0] pal_default(input logic [2:0] idx);
    logic [COLOR_W-1:0] ones;
    logic [COLOR_W-1:0] zero;
    ones = {COLOR_W{1'b1}};
    zero = {COLOR_W{1'b0}};
    case (idx)
      3'd0:    return {zero, ones, zero};
      3'd1:    return {ones, ones, zero};
      3'd2:    return {ones, zero, zero};
      default: return {PIX_W{1'b0}};
    endcase
  endfunction

  // The palette array is sized to the full 3-bit index space; entries at or
  // above NUM_BANDS are tied to black so writes to them fall away silently.
  logic [PIX_W-1:0] pal_q [8];
  logic [PIX_W-1:0] pal_d [8];
  logic [OFF_W-1:0] offset_q, offset_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;
  logic             pixel_valid_q, pixel_valid_d;

  logic [COORD_W-1:0] coord_s;
  logic [SUM_W-1:0]   sum_s;
  logic [SUM_W-1:0]   quot_s;
  logic [2:0]         band_s;
  logic [PIX_W-1:0]   colour_s;

  // Palette next state: one write per cycle, visible from the next cycle.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (i >= NUM_BANDS) begin
        pal_d[i] = {PIX_W{1'b0}};
      end else if (bus.pal_wr && (bus.pal_idx == 3'(i))) begin
        pal_d[i] = bus.pal_data;
      end else begin
        pal_d[i] = pal_q[i];
      end
    end
  end

  // Scroll state: fcnt divides frame_start, offset advances modulo PERIOD.
  always_comb begin
    fcnt_d   = fcnt_q;
    offset_d = offset_q;
    if (bus.scroll_en && bus.frame_start) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d = {FC_W{1'b0}};
        if (offset_q == OFF_LAST) begin
          offset_d = {OFF_W{1'b0}};
        end else begin
          offset_d = offset_q + OFF_W'(1);
        end
      end else begin
        fcnt_d   = fcnt_q + FC_W'(1);
        offset_d = offset_q;
      end
    end else begin
      fcnt_d   = fcnt_q;
      offset_d = offset_q;
    end
  end

  // Pixel path: pick the coordinate, locate the band, look up its colour.
  always_comb begin
    if (bus.mode) begin
      coord_s = bus.x;
    end else begin
      coord_s = bus.y;
    end
    sum_s    = SUM_W'(coord_s) + SUM_W'(offset_q);
    quot_s   = sum_s / BAND_SIZE_S;
    band_s   = 3'(quot_s % NUM_BANDS_S);
    colour_s = pal_q[band_s];
`ifdef COLOR_BAND_GEN_BORDER_EN
    if ((sum_s % BAND_SIZE_S) == {SUM_W{1'b0}}) begin
      colour_s = {PIX_W{1'b1}};
    end else begin
      colour_s = pal_q[band_s];
    end
`endif
    if (bus.pixel_on) begin
      rgb_d = colour_s;
    end else begin
      rgb_d = {PIX_W{1'b0}};
    end
    pixel_valid_d = bus.pixel_on;
  end

  // State and output registers; reset overrides palette writes and scrolling.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        pal_q[i] <= (i < NUM_BANDS) ? pal_default(3'(i)) : {PIX_W{1'b0}};
      end
      offset_q      <= {OFF_W{1'b0}};
      fcnt_q        <= {FC_W{1'b0}};
      rgb_q         <= {PIX_W{1'b0}};
      pixel_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        pal_q[i] <= pal_d[i];
      end
      offset_q      <= offset_d;
      fcnt_q        <= fcnt_d;
      rgb_q         <= rgb_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign bus.red_out     = rgb_q[PIX_W-1 -: COLOR_W];
  assign bus.green_out   = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign bus.blue_out    = rgb_q[COLOR_W-1:0];
  assign bus.pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_color_band_gen.sv
// -----------------------------------------------------------------------------
// tb_color_band_gen
// Scoreboard bench: the driver computes each cycle's expected output from a
// behavioural model (palette array, integer offset and frame count) and queues
// it; an independent monitor pops one entry per cycle and compares.
// -----------------------------------------------------------------------------
module tb_color_band_gen;
  localparam int CW = 4;
  localparam int XW = 10;
  localparam int NB = 3;
  localparam int BS = 160;
  localparam int SD = 4;
  localparam int P  = NB * BS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  color_band_gen_if #(.COLOR_W(CW), .COORD_W(XW)) bus ();

  color_band_gen #(
    .COLOR_W(CW), .COORD_W(XW), .NUM_BANDS(NB), .BAND_SIZE(BS), .SCROLL_DIV(SD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [12:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [11:0] pal_m [8];
  int off_m;
  int fcnt_m;

  function automatic logic [11:0] def_col(input int i);
    case (i)
      0:       return 12'h0F0;
      1:       return 12'hFF0;
      2:       return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) pal_m[i] = def_col(i);
    off_m  = 0;
    fcnt_m = 0;
  endtask

  // Queue the expectation for the inputs now on the bus, advance the model,
  // then let one clock edge happen.
  task automatic step();
    int coord;
    int band;
    logic [11:0] col;
    logic [12:0] e;
    coord = bus.mode ? int'(bus.x) : int'(bus.y);
    band  = ((coord + off_m) / BS) % NB;
    col   = pal_m[band];
`ifdef COLOR_BAND_GEN_BORDER_EN
    if (((coord + off_m) % BS) == 0) col = 12'hFFF;
`endif
    if (reset)             e = 13'h0000;
    else if (bus.pixel_on) e = {1'b1, col};
    else                   e = 13'h0000;
    exp_q.push_back(e);
    if (reset) begin
      model_reset();
    end else begin
      if (bus.pal_wr && (int'(bus.pal_idx) < NB)) pal_m[bus.pal_idx] = bus.pal_data;
      if (bus.scroll_en && bus.frame_start) begin
        fcnt_m++;
        if (fcnt_m == SD) begin
          fcnt_m = 0;
          off_m  = (off_m + 1) % P;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit po, input int xv, input int yv, input bit md,
                       input bit fs, input bit se, input bit wr, input int idx,
                       input logic [11:0] d, input bit rst);
    bus.pixel_on    = po;
    bus.x           = XW'(xv);
    bus.y           = XW'(yv);
    bus.mode        = md;
    bus.frame_start = fs;
    bus.scroll_en   = se;
    bus.pal_wr      = wr;
    bus.pal_idx     = 3'(idx);
    bus.pal_data    = d;
    reset           = rst;
    step();
  endtask

  task automatic pix(input int yv);
    drive(1'b1, 0, yv, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b0);
  endtask

  task automatic pulse();
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 12'h000, 1'b0);
  endtask

  // Monitor: one output per cycle, compared against the queued expectation.
  logic [12:0] mon_exp;
  logic [12:0] mon_act;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {bus.pixel_valid, bus.red_out, bus.green_out, bus.blue_out};
        n_tests++;
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL pixel @%0t: got valid/rgb %h, expected %h", $time, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    model_reset();
    bus.pixel_on = 1'b0; bus.x = '0; bus.y = '0; bus.mode = 1'b0;
    bus.frame_start = 1'b0; bus.scroll_en = 1'b0; bus.pal_wr = 1'b0;
    bus.pal_idx = 3'd0; bus.pal_data = 12'h000; reset = 1'b1;
    @(negedge clk);
    // Reset, with pixel_on high to show outputs are forced to zero.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b1);
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b1);
    // Band boundaries along y.
    pix(159); pix(160); pix(319); pix(320); pix(479); pix(480);
    // Blanking.
    drive(1'b0, 0, 200, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b0);
    // Bands along x.
    drive(1'b1, 330, 10, 1'b1, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b0);
    // Palette writes: in range, out of range, then same-cycle write and read.
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 12'h00F, 1'b0);
    pix(200);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 12'h123, 1'b0);
    pix(0); pix(200); pix(400);
    drive(1'b1, 0, 200, 1'b0, 1'b0, 1'b0, 1'b1, 1, 12'h5A5, 1'b0);
    pix(200);
    // Scrolling from reset: four pulses move the bands by one pixel.
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b1);
    for (int i = 0; i < 4; i++) pulse();
    pix(159);
    // Frame pulses ignored while scrolling is disabled.
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h000, 1'b0);
    pix(159);
    // Advance to offset 479, then four more pulses wrap to 0.
    for (int i = 0; i < 1912; i++) pulse();
    pix(0); pix(1);
    for (int i = 0; i < 4; i++) pulse();
    pix(0); pix(159);
    // Reset mid-frame after scrolling and a palette write, colliding with both.
    for (int i = 0; i < 28; i++) pulse();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 12'h321, 1'b0);
    pix(200);
    drive(1'b1, 0, 200, 1'b0, 1'b1, 1'b1, 1'b1, 1, 12'h777, 1'b1);
    pix(200); pix(160); pix(0);
    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
            12'($urandom), 1'($urandom_range(0, 60) == 0));
    end
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/color_band_gen.md
COLOR_BAND_GEN -- requirements
Module: color_band_gen

Interface
REQ-001 SHALL have parameter COLOR_W, default 4: bits per colour channel.
REQ-002 SHALL have parameter COORD_W, default 10: width of x and y.
REQ-003 SHALL have parameter NUM_BANDS, default 3, legal 2..8: number of colour bands.
REQ-004 SHALL have parameter BAND_SIZE, default 160: band thickness in pixels.
REQ-005 SHALL have parameter SCROLL_DIV, default 4, min 1: frame_start pulses per one-pixel scroll step.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port pixel_on, input, 1: active-video qualifier.
REQ-009 SHALL have ports x and y, input, COORD_W each: current pixel coordinates.
REQ-010 SHALL have port frame_start, input, 1: one-cycle pulse, once per frame.
REQ-011 SHALL have port mode, input, 1: 0 = bands stacked along y, 1 = bands stacked along x.
REQ-012 SHALL have port scroll_en, input, 1: enables band scrolling.
REQ-013 SHALL have ports pal_wr (1), pal_idx (3) and pal_data (3*COLOR_W, {R,G,B}), inputs: palette write port.
REQ-014 SHALL have ports red_out, green_out and blue_out, output, COLOR_W each: registered colour.
REQ-015 SHALL have port pixel_valid, output, 1: pixel_on delayed to align with colour.

Function
REQ-016 SHALL select coord = y when mode=0 and coord = x when mode=1.
REQ-017 SHALL compute band = ((coord + offset) / BAND_SIZE) mod NUM_BANDS with no truncation; the sum carries at least COORD_W+4 bits.
REQ-018 SHALL use period P = NUM_BANDS*BAND_SIZE; offset range is 0..P-1.
REQ-019 SHALL register outputs with 1-cycle latency: inputs sampled at edge n appear after edge n.
REQ-020 SHALL output palette[band] when pixel_on=1, and all zeros when pixel_on=0.
REQ-021 SHALL register pixel_valid as pixel_on from the previous cycle.
REQ-022 SHALL hold NUM_BANDS palette entries of 3*COLOR_W bits each.
REQ-023 SHALL write pal_data into entry pal_idx on each cycle that pal_wr=1.
REQ-024 SHALL treat pal_idx >= NUM_BANDS as a silent no-op.
REQ-025 SHALL make a palette write visible to pixels sampled from the next cycle onward; a pixel sampled in the same cycle as a write to its entry uses the old value.
REQ-026 SHALL, when scroll_en=1, increment frame counter fcnt (0..SCROLL_DIV-1) on each frame_start.
REQ-027 SHALL, when fcnt = SCROLL_DIV-1 and frame_start=1, clear fcnt to 0 and advance offset by 1, wrapping from P-1 to 0.
REQ-028 SHALL, when scroll_en=0, hold fcnt and offset and ignore frame_start.
REQ-029 SHALL apply a mode change combinationally to the next sampled pixel, with no frame synchronisation.

Reset
REQ-030 SHALL, when reset=1 at a clock edge, clear red_out, green_out, blue_out, pixel_valid, fcnt and offset to 0.
REQ-031 SHALL, on reset, load palette defaults: entry 0 = green (G all ones), entry 1 = yellow (R and G all ones), entry 2 = red (R all ones), entries 3..7 = black.
REQ-032 SHALL give reset priority over palette writes and scroll updates in the same cycle, including reset asserted mid-frame.

Configuration
REQ-033 SHALL, with macro COLOR_BAND_GEN_BORDER_EN defined, output white (all channels all ones) when pixel_on=1 and (coord + offset) mod BAND_SIZE = 0.
REQ-034 SHALL, without COLOR_BAND_GEN_BORDER_EN, omit border logic entirely; colour is palette[band] only.

Verification (defaults; F = 4'hF)
REQ-035 SHALL cover: reset, mode=0, pixel_on=1, y = 159/160/319/320/479/480 -> one cycle later RGB = 0F0/FF0/FF0/F00/F00/0F0, pixel_valid=1.
REQ-036 SHALL cover: pixel_on=0, y=200 -> RGB=000, pixel_valid=0 one cycle later.
REQ-037 SHALL cover: scroll_en=1, 4 frame_start pulses -> offset=1, y=159 gives FF0; preloaded offset 479 plus 4 pulses -> offset=0.
REQ-038 SHALL cover: pal_wr, idx=1, data=12'h00F, then y=200 -> RGB=00F; idx=3 write -> no change to any entry; same-cycle write and read of entry 1 -> old colour.
REQ-039 SHALL cover: mode=1, x=330, y=10 -> RGB=F00.
REQ-040 SHALL cover: reset asserted after offset=7 and a palette write -> offset 0, palette defaults, y=200 gives FF0; with BORDER_EN, y=160 gives FFF.
